// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester-side handshake and the FIFO write port seen by the
// write-side arbiter.
//   req_valid / req_last / req_data : per-requester word offer (packed data,
//                                     requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready                       : word accepted this cycle (one-hot or zero)
//   wfull                           : FIFO full flag (wclk domain)
//   winc / wdata                    : FIFO write enable and write data
// Modports:
//   master : requesters + FIFO (drive offers and wfull, observe acceptance/writes)
//   slave  : the arbiter
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wfull;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;

  modport master (
    output req_valid,
    output req_last,
    output req_data,
    output wfull,
    input  req_ready,
    input  winc,
    input  wdata
  );

  modport slave (
    input  req_valid,
    input  req_last,
    input  req_data,
    input  wfull,
    output req_ready,
    output winc,
    output wdata
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares one asynchronous-FIFO write port among NUM_REQ requesters in the wclk
// domain. Arbitration is round-robin and burst-locked: the owner keeps the
// port until it ends its packet, reaches MAX_BURST words, or drops valid.
// Every grant costs one IDLE cycle.
//
// Ports:
//   wclk      : write-domain clock
//   wrst      : asynchronous active-high reset (aborts any burst at once)
//   bus       : fifo_wr_arbiter_if.slave (requester offers, FIFO write port)
//   grant_id  : index of the current / most recent owner
//   busy      : port locked to a requester
//   stall_cnt : saturating count of locked cycles with wfull=1 and owner valid
//
// Build option:
//   FIFO_WR_ARB_PRIO_EN : when defined, requester 0 wins every IDLE arbitration
//                         it takes part in; others rotate round-robin. A
//                         locked burst is never preempted.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                       wclk,
  input  logic                       wrst,
  fifo_wr_arbiter_if.slave           bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [7:0]                 stall_cnt
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [BW-1:0] BURST_LIM  = BW'(MAX_BURST);
  localparam logic [BW-1:0] BEAT_ONE   = BW'(1'b1);
  localparam logic [BW-1:0] BEAT_ZERO  = {BW{1'b0}};
  localparam logic [GW-1:0] GRANT_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] LAST_RST   = GW'(NUM_REQ - 1);
  localparam logic [7:0]    STALL_MAX  = 8'd255;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [GW-1:0]   grant_r;
  logic [GW-1:0]   last_grant_r;
  logic [BW-1:0]   beat_cnt_r;
  logic [7:0]      stall_cnt_r;
  logic            busy_r;

  logic [GW-1:0]   pick_s;
  logic [GW-1:0]   cand_s;
  logic [BW-1:0]   beat_nxt_s;
  logic            owner_valid_s;
  logic            owner_last_s;
  logic            any_valid_s;
  logic            beat_s;
  logic            release_s;

  // Index base+offset wrapped into 0..NUM_REQ-1 (offset is at most NUM_REQ).
  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base,
                                             input int            offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return GW'(sum);
  endfunction

  // Owner-side view of the request bus.
  always_comb begin
    owner_valid_s = bus.req_valid[grant_r];
    owner_last_s  = bus.req_last[grant_r];
    any_valid_s   = |bus.req_valid;
  end

  // Round-robin winner search starting after last_grant_r. The loop runs from
  // the farthest candidate to the nearest, so the nearest valid one wins.
  always_comb begin
    pick_s = last_grant_r;
    cand_s = last_grant_r;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_s = wrap_idx(last_grant_r, k);
`ifdef FIFO_WR_ARB_PRIO_EN
      // Requester 0 is handled by the override below, not by the rotation.
      pick_s = ((cand_s != GRANT_ZERO) && bus.req_valid[cand_s]) ? cand_s : pick_s;
`else
      pick_s = bus.req_valid[cand_s] ? cand_s : pick_s;
`endif
    end
`ifdef FIFO_WR_ARB_PRIO_EN
    if (bus.req_valid[0]) begin
      pick_s = GRANT_ZERO;
    end else begin
      pick_s = pick_s;
    end
`endif
  end

  // Beat detection and release conditions while locked. A release caused by
  // last and by MAX_BURST on the same beat is naturally a single release.
  always_comb begin
    beat_s     = (state_r == LOCK) && owner_valid_s && !bus.wfull;
    beat_nxt_s = beat_cnt_r + BEAT_ONE;
    release_s  = (state_r == LOCK) &&
                 (!owner_valid_s ||
                  (beat_s && (owner_last_s || (beat_nxt_s == BURST_LIM))));
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = any_valid_s ? LOCK : IDLE;
      LOCK:    state_nxt_s = release_s ? IDLE : LOCK;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FIFO write port and acceptance; combinational so a reset kills them at once.
  always_comb begin
    bus.winc      = beat_s;
    bus.req_ready = beat_s ? (NUM_REQ'(1'b1) << grant_r) : {NUM_REQ{1'b0}};
    bus.wdata     = bus.req_data[grant_r*DATA_WIDTH +: DATA_WIDTH];
  end

  // State register.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant, burst and stall bookkeeping.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      grant_r      <= GRANT_ZERO;
      last_grant_r <= LAST_RST;
      beat_cnt_r   <= BEAT_ZERO;
      busy_r       <= 1'b0;
      stall_cnt_r  <= 8'd0;
    end else begin
      if ((state_r == IDLE) && any_valid_s) begin
        grant_r    <= pick_s;
        busy_r     <= 1'b1;
        beat_cnt_r <= BEAT_ZERO;
      end else begin
        if (beat_s) begin
          beat_cnt_r <= beat_nxt_s;
        end
        if (release_s) begin
          last_grant_r <= grant_r;
          busy_r       <= 1'b0;
        end
      end
      // wfull only blocks beats; it never releases the lock.
      if ((state_r == LOCK) && bus.wfull && owner_valid_s &&
          (stall_cnt_r != STALL_MAX)) begin
        stall_cnt_r <= stall_cnt_r + 8'd1;
      end
    end
  end

  // Registered status outputs.
  always_comb begin
    grant_id  = grant_r;
    busy      = busy_r;
    stall_cnt = stall_cnt_r;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (default parameters NUM_REQ=3,
// DATA_WIDTH=8, MAX_BURST=4). A cycle-level behavioural model of the arbiter
// rules predicts every output; directed scenarios add fixed expectations.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int MB = 4;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic [1:0] grant_id;
  logic       busy;
  logic [7:0] stall_cnt;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  bit m_locked;
  int m_owner, m_last, m_beats, m_stall, m_gid;

  // per-cycle predictions and observations
  logic [31:0]  exp_pk, obs_pk;
  bit           exp_winc;
  logic [N-1:0] exp_ready;
  logic         obs_winc, obs_busy;
  logic [N-1:0] obs_ready;
  logic [1:0]   obs_gid;
  logic [7:0]   obs_stall, obs_wd;

  task automatic model_reset();
    m_locked = 1'b0; m_owner = 0; m_last = N - 1; m_beats = 0; m_stall = 0; m_gid = 0;
  endtask

  function automatic int pick_model(logic [N-1:0] v);
`ifdef FIFO_WR_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
`ifdef FIFO_WR_ARB_PRIO_EN
      if (c != 0 && v[c]) return c;
`else
      if (v[c]) return c;
`endif
    end
    return -1;
  endfunction

  // One clock: predict and sample at negedge, advance the model at posedge.
  task automatic tick();
    logic [DW-1:0] wd_e;
    @(negedge wclk);
    exp_winc  = m_locked && bus.req_valid[m_owner] && !bus.wfull;
    exp_ready = exp_winc ? (N'(1) << m_owner) : '0;
    wd_e      = exp_winc ? bus.req_data[m_owner*DW +: DW] : 8'd0;
    exp_pk    = {9'd0, exp_winc, exp_ready, m_locked, 2'(m_gid), 8'(m_stall), wd_e};
    obs_winc  = bus.winc;
    obs_ready = bus.req_ready;
    obs_busy  = busy;
    obs_gid   = grant_id;
    obs_stall = stall_cnt;
    obs_wd    = bus.winc ? bus.wdata : 8'd0;
    obs_pk    = {9'd0, obs_winc, obs_ready, obs_busy, obs_gid, obs_stall, obs_wd};
    @(posedge wclk);
    if (!m_locked) begin
      int p;
      p = pick_model(bus.req_valid);
      if (p >= 0) begin m_locked = 1'b1; m_owner = p; m_gid = p; m_beats = 0; end
    end else begin
      if (bus.wfull && bus.req_valid[m_owner] && m_stall < 255) m_stall++;
      if (exp_winc) begin
        m_beats++;
        if (bus.req_last[m_owner] || m_beats == MB) begin m_locked = 1'b0; m_last = m_owner; end
      end else if (!bus.req_valid[m_owner]) begin
        m_locked = 1'b0; m_last = m_owner;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    bus.req_valid = '0; bus.req_last = '0; bus.wfull = 1'b0;
    model_reset();
    repeat (2) @(posedge wclk);
    #1 wrst = 1'b0;
  endtask

  task automatic test_reset();
    wrst = 1'b1;
    bus.req_valid = 3'b111; bus.req_last = 3'b111; bus.wfull = 1'b0;
    bus.req_data = 24'h332211;
    model_reset();
    repeat (2) @(posedge wclk);
    #1;
    if ({bus.winc, bus.req_ready, busy, grant_id, stall_cnt} !== 15'd0) begin
      n_err++; $display("FAIL reset_outputs got=%h exp=0", {bus.winc, bus.req_ready, busy, grant_id, stall_cnt});
    end
    n_vec++;
    bus.req_valid = '0;
    wrst = 1'b0;
    tick();
    if (obs_pk !== exp_pk) begin n_err++; $display("FAIL reset_idle got=%h exp=%h", obs_pk, exp_pk); end
    n_vec++;
  endtask

  task automatic test_round_robin();
    logic [7:0] wseq = 8'd0;
    int gq[$];
    bus.req_valid = 3'b111; bus.req_last = 3'b111; bus.wfull = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (obs_pk !== exp_pk) begin n_err++; $display("FAIL rr_cycle%0d got=%h exp=%h", c, obs_pk, exp_pk); end
      n_vec++;
      wseq = {wseq[6:0], obs_winc};
      if (obs_winc) gq.push_back(int'(obs_gid));
      for (int i = 0; i < N; i++) if (obs_ready[i]) bus.req_data[i*DW +: DW] = 8'($urandom);
    end
    if (wseq !== 8'b01010101) begin n_err++; $display("FAIL rr_winc_pattern got=%b exp=01010101", wseq); end
    n_vec++;
    if (gq.size() != 4) begin
      n_err++; $display("FAIL rr_grant_count got=%0d exp=4", gq.size());
    end else if ({gq[0], gq[1], gq[2], gq[3]} !== {0, 1, 2, 0}) begin
      n_err++; $display("FAIL rr_grant_order got=%0d,%0d,%0d,%0d exp=0,1,2,0", gq[0], gq[1], gq[2], gq[3]);
    end
    n_vec++;
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_burst_split();
    int idx = 0, cur = 0;
    int bursts[$];
    bus.req_valid = 3'b010; bus.req_last = '0; bus.wfull = 1'b0;
    bus.req_data[DW +: DW] = 8'd0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (obs_pk !== exp_pk) begin n_err++; $display("FAIL burst_cycle%0d got=%h exp=%h", c, obs_pk, exp_pk); end
      n_vec++;
      if (!obs_busy && cur > 0) begin bursts.push_back(cur); cur = 0; end
      if (obs_winc) begin
        cur++; idx++;
        if (idx >= 10) bus.req_valid = '0; else bus.req_data[DW +: DW] = 8'(idx);
      end
    end
    if (cur > 0) bursts.push_back(cur);
    if (bursts.size() != 3) begin
      n_err++; $display("FAIL burst_count got=%0d exp=3", bursts.size());
    end else if ({bursts[0], bursts[1], bursts[2]} !== {4, 4, 2}) begin
      n_err++; $display("FAIL burst_lengths got=%0d,%0d,%0d exp=4,4,2", bursts[0], bursts[1], bursts[2]);
    end
    n_vec++;
    if (grant_id !== 2'd1) begin n_err++; $display("FAIL burst_grant got=%0d exp=1", grant_id); end
    n_vec++;
  endtask

  task automatic test_stall();
    do_reset();
    bus.req_valid = 3'b100; bus.req_last = '0;
    bus.req_data[2*DW +: DW] = 8'hA0;
    for (int c = 0; c < 9; c++) begin
      bus.wfull = (c >= 2 && c < 7);
      tick();
      if (obs_pk !== exp_pk) begin n_err++; $display("FAIL stall_cycle%0d got=%h exp=%h", c, obs_pk, exp_pk); end
      n_vec++;
      if (c == 7) begin
        if ({obs_winc, obs_busy, obs_stall, obs_wd} !== {1'b1, 1'b1, 8'd5, 8'hA1}) begin
          n_err++; $display("FAIL stall_resume got=%h exp=%h", {obs_winc, obs_busy, obs_stall, obs_wd}, {1'b1, 1'b1, 8'd5, 8'hA1});
        end
        n_vec++;
      end
      if (obs_winc) bus.req_data[2*DW +: DW] = bus.req_data[2*DW +: DW] + 8'd1;
    end
    bus.req_valid = '0;
    repeat (2) tick();
  endtask

  task automatic test_stall_saturate();
    do_reset();
    bus.req_valid = 3'b001; bus.req_last = '0; bus.req_data[0 +: DW] = 8'h3C;
    tick();
    bus.wfull = 1'b1;
    for (int c = 0; c < 262; c++) begin
      tick();
      if (obs_pk !== exp_pk) begin n_err++; $display("FAIL sat_cycle%0d got=%h exp=%h", c, obs_pk, exp_pk); end
      n_vec++;
    end
    #4;
    if ({busy, stall_cnt} !== {1'b1, 8'd255}) begin
      n_err++; $display("FAIL stall_saturate got=%h exp=%h", {busy, stall_cnt}, {1'b1, 8'd255});
    end
    n_vec++;
    bus.wfull = 1'b0; bus.req_valid = '0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req_valid = 3'b010; bus.req_last = '0; bus.req_data = 24'h00_77_00;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (obs_pk !== exp_pk) begin n_err++; $display("FAIL rstmid_cycle%0d got=%h exp=%h", c, obs_pk, exp_pk); end
      n_vec++;
    end
    #1 wrst = 1'b1;
    #1;
    if ({bus.winc, bus.req_ready, busy} !== 5'd0) begin
      n_err++; $display("FAIL rstmid_abort got=%b exp=00000", {bus.winc, bus.req_ready, busy});
    end
    n_vec++;
    model_reset();
    @(posedge wclk);
    #1 wrst = 1'b0;
    bus.req_valid = 3'b111; bus.req_last = 3'b111;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (obs_pk !== exp_pk) begin n_err++; $display("FAIL rstmid_after%0d got=%h exp=%h", c, obs_pk, exp_pk); end
      n_vec++;
    end
    if ({obs_winc, obs_gid} !== {1'b1, 2'd0}) begin
      n_err++; $display("FAIL rstmid_first_grant got=%h exp=%h", {obs_winc, obs_gid}, {1'b1, 2'd0});
    end
    n_vec++;
    bus.req_valid = '0;
    repeat (2) tick();
  endtask

  task automatic test_last_max();
    int idx = 0;
    logic [6:0] wseq = 7'd0;
    do_reset();
    bus.req_valid = 3'b011; bus.req_last = 3'b000;
    bus.req_data = 24'h00_55_10;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (obs_pk !== exp_pk) begin n_err++; $display("FAIL lastmax_cycle%0d got=%h exp=%h", c, obs_pk, exp_pk); end
      n_vec++;
      if (c < 7) wseq = {wseq[5:0], obs_winc};
      if (c == 6 && {obs_winc, obs_gid} !== {1'b1, 2'd1}) begin
        n_err++; $display("FAIL lastmax_next_grant got=%h exp=%h", {obs_winc, obs_gid}, {1'b1, 2'd1});
      end
      if (c == 6) n_vec++;
      if (obs_ready[0]) begin
        idx++;
        if (idx >= 4) bus.req_valid[0] = 1'b0;
        else begin bus.req_data[0 +: DW] = 8'(8'h10 + idx); bus.req_last[0] = (idx == 3); end
      end
    end
    if (wseq !== 7'b0111101) begin n_err++; $display("FAIL lastmax_winc_pattern got=%b exp=0111101", wseq); end
    n_vec++;
    bus.req_valid = '0; bus.req_last = '0;
    repeat (2) tick();
  endtask

  task automatic test_prio();
    logic [1:0] exp_g;
`ifdef FIFO_WR_ARB_PRIO_EN
    exp_g = 2'd0;
`else
    exp_g = 2'd2;
`endif
    do_reset();
    bus.req_valid = 3'b101; bus.req_last = 3'b101; bus.req_data = 24'hC2_00_C0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (obs_pk !== exp_pk) begin n_err++; $display("FAIL prio_cycle%0d got=%h exp=%h", c, obs_pk, exp_pk); end
      n_vec++;
    end
    if ({obs_winc, obs_gid} !== {1'b1, exp_g}) begin
      n_err++; $display("FAIL prio_second_grant got=%h exp=%h", {obs_winc, obs_gid}, {1'b1, exp_g});
    end
    n_vec++;
    bus.req_valid = '0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic [N-1:0]    rv = '0, rl = '0;
    logic [N*DW-1:0] rd = '0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rv[i] && !obs_ready[i]) begin
          if ($urandom_range(0, 15) == 0) rv[i] = 1'b0;
        end else begin
          rv[i] = ($urandom_range(0, 2) != 0);
          rl[i] = ($urandom_range(0, 3) == 0);
          rd[i*DW +: DW] = 8'($urandom);
        end
      end
      bus.req_valid = rv; bus.req_last = rl; bus.req_data = rd;
      bus.wfull = ($urandom_range(0, 3) == 0);
      tick();
      if (obs_pk !== exp_pk) begin n_err++; $display("FAIL rand_cycle%0d got=%h exp=%h", c, obs_pk, exp_pk); end
      n_vec++;
    end
  endtask

  initial begin
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.wfull = 1'b0;
    obs_ready = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_burst_split();
    test_stall();
    test_stall_saturate();
    test_reset_mid_burst();
    test_last_max();
    test_prio();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
